// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcodes and the datapath select codes driven by the controller.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle: IR fields and ALU flags in,
// memory handshake, datapath selects/enables and status out.
interface multicycle_controller_if #(
    parameter int INSTRET_WIDTH = 32
);
    logic [6:0]               op;
    logic [2:0]               funct3;
    logic                     funct7b5;
    logic                     zero;
    logic                     sign_flag;
    logic                     mem_ready;

    logic                     mem_req;
    logic                     MemWrite;
    logic                     AdrSrc;
    logic                     IRWrite;
    logic                     PCWrite;
    logic                     RegWrite;
    logic [1:0]               ResultSrc;
    logic [1:0]               ALUSrcA;
    logic [1:0]               ALUSrcB;
    logic [1:0]               ImmSrc;
    logic [2:0]               ALU_control;
    logic                     illegal;
    logic [INSTRET_WIDTH-1:0] instret;

    modport master (
        input  op, funct3, funct7b5, zero, sign_flag, mem_ready,
        output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALU_control, illegal, instret
    );

    modport slave (
        output op, funct3, funct7b5, zero, sign_flag, mem_ready,
        input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALU_control, illegal, instret
    );

endinterface

// File: rtl/alu_decoder.sv
// funct3/funct7b5 -> ALU operation for register and immediate ALU ops,
// flagging the encodings the core does not implement.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic       is_rtype,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (funct3)
            // funct7b5 on an I-type add is an immediate bit, not SUB
            3'b000:  alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_control = ALU_SLL;
            3'b010:  alu_control = ALU_SLT;
            3'b100:  alu_control = ALU_XOR;
            3'b101:  begin
                alu_control = ALU_SRL;
                illegal     = funct7b5;
            end
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and writeback steps and counts retired instructions.
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int INSTRET_WIDTH   = 32,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    multicycle_controller_if.master bus
);

    localparam state_t ILL_STATE = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

    state_t                   st, nxt;
    logic                     mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;
    logic                     adr_src, retire;
    logic [1:0]               result_src, src_a, src_b;
    logic [2:0]               alu_ctl, dec_ctl;
    logic                     dec_illegal, taken, br_legal;
    logic [INSTRET_WIDTH-1:0] instret_q;

    alu_decoder u_alu_dec (
        .is_rtype    (st == S_EXECUTER),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .alu_control (dec_ctl),
        .illegal     (dec_illegal)
    );

    always_comb begin
        taken    = 1'b0;
        br_legal = 1'b1;
        case (bus.funct3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = ~bus.zero;
            3'b100:  taken = bus.sign_flag;
            3'b101:  taken = ~bus.sign_flag;
            default: br_legal = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) st <= S_FETCH;
        else      st <= nxt;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)        instret_q <= '0;
        else if (retire) instret_q <= instret_q + INSTRET_WIDTH'(1);
    end

    always_comb begin
        nxt         = st;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        adr_src     = 1'b0;
        retire      = 1'b0;
        result_src  = RES_ALUOUT;
        src_a       = SRCA_PC;
        src_b       = SRCB_RS2;
        alu_ctl     = ALU_ADD;
        case (st)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                src_b      = SRCB_FOUR;
                result_src = RES_ALU;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    nxt        = S_DECODE;
                end
            end
            S_DECODE: begin
                // OldPC + imm parks the branch/jump target in ALUOut
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                case (bus.op)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_RTYPE:          nxt = S_EXECUTER;
                    OP_ITYPE:          nxt = S_EXECUTEI;
                    OP_BRANCH:         nxt = S_BRANCH;
                    OP_JAL:            nxt = S_JAL;
                    default:           nxt = ILL_STATE;
                endcase
            end
            S_MEMADR: begin
                src_a = SRCA_RS1;
                src_b = SRCB_IMM;
                if (bus.funct3 == 3'b010)
                    nxt = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                else
                    nxt = ILL_STATE;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src   = 1'b1;
                if (bus.mem_ready) nxt = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = RES_RDATA;
                reg_write_c = 1'b1;
                retire      = 1'b1;
                nxt         = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src     = 1'b1;
                if (bus.mem_ready) begin
                    retire = 1'b1;
                    nxt    = S_FETCH;
                end
            end
            S_EXECUTER, S_EXECUTEI: begin
                src_a   = SRCA_RS1;
                src_b   = (st == S_EXECUTER) ? SRCB_RS2 : SRCB_IMM;
                alu_ctl = dec_ctl;
                nxt     = dec_illegal ? ILL_STATE : S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                retire      = 1'b1;
                nxt         = S_FETCH;
            end
            S_BRANCH: begin
                src_a   = SRCA_RS1;
                alu_ctl = ALU_SUB;
                if (br_legal) begin
                    pc_write_c = taken;
                    retire     = 1'b1;
                    nxt        = S_FETCH;
                end else begin
                    nxt = ILL_STATE;
                end
            end
            S_JAL: begin
                // PC takes the target from ALUOut while OldPC+4 goes to ALUOut
                src_a      = SRCA_OLDPC;
                src_b      = SRCB_FOUR;
                pc_write_c = 1'b1;
                nxt        = S_ALUWB;
            end
            S_TRAP:  nxt = S_TRAP;
            default: nxt = S_FETCH;
        endcase
    end

    // Enables and the memory request are dropped combinationally during reset
    assign bus.mem_req     = mem_req_c & RST;
    assign bus.MemWrite    = mem_write_c & RST;
    assign bus.IRWrite     = ir_write_c & RST;
    assign bus.PCWrite     = pc_write_c & RST;
    assign bus.RegWrite    = reg_write_c & RST;
    assign bus.AdrSrc      = adr_src;
    assign bus.ResultSrc   = result_src;
    assign bus.ALUSrcA     = src_a;
    assign bus.ALUSrcB     = src_b;
    assign bus.ALU_control = alu_ctl;
    assign bus.ImmSrc      = imm_src_of(bus.op);
    assign bus.illegal     = (st == S_TRAP);
    assign bus.instret     = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a trapping 32-bit-counter instance and a
// non-trapping 4-bit-counter instance share one stimulus stream.
module tb_multicycle_controller;

    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_J = 7'b1101111;
    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;

    // {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
    //  ResultSrc, ALUSrcA, ALUSrcB, ALU_control, ImmSrc, illegal}
    typedef logic [17:0] out_t;
    typedef struct packed { logic rdy; out_t e; } step_t;
    typedef struct {
        string      nm;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z, s;
        int         cpi;
        logic [2:0] alu;
        logic [1:0] sb;
        int         rg, pw;
    } vec_t;
    typedef struct { logic [6:0] op; logic [2:0] f3; logic f7; int stage; } ill_t;

    logic CLK = 1'b0;
    logic RST;
    int   n_vec = 0, n_bad = 0;
    logic [31:0] cnt;

    multicycle_controller_if #(.INSTRET_WIDTH(32)) b0 ();
    multicycle_controller_if #(.INSTRET_WIDTH(4))  b1 ();

    assign b1.op        = b0.op;
    assign b1.funct3    = b0.funct3;
    assign b1.funct7b5  = b0.funct7b5;
    assign b1.zero      = b0.zero;
    assign b1.sign_flag = b0.sign_flag;
    assign b1.mem_ready = b0.mem_ready;

    multicycle_controller #(.INSTRET_WIDTH(32), .TRAP_ON_ILLEGAL(1'b1)) dut0 (
        .CLK(CLK), .RST(RST), .bus(b0));
    multicycle_controller #(.INSTRET_WIDTH(4), .TRAP_ON_ILLEGAL(1'b0)) dut1 (
        .CLK(CLK), .RST(RST), .bus(b1));

    always #5 CLK = ~CLK;

    out_t a0, a1;
    assign a0 = {b0.mem_req, b0.MemWrite, b0.AdrSrc, b0.IRWrite, b0.PCWrite, b0.RegWrite,
                 b0.ResultSrc, b0.ALUSrcA, b0.ALUSrcB, b0.ALU_control, b0.ImmSrc, b0.illegal};
    assign a1 = {b1.mem_req, b1.MemWrite, b1.AdrSrc, b1.IRWrite, b1.PCWrite, b1.RegWrite,
                 b1.ResultSrc, b1.ALUSrcA, b1.ALUSrcB, b1.ALU_control, b1.ImmSrc, b1.illegal};

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic chk(input string nm, input out_t e, input logic [31:0] c);
        cmp({nm, "/d0"}, 32'(a0), 32'(e));
        cmp({nm, "/d0_instret"}, b0.instret, c);
        cmp({nm, "/d1"}, 32'(a1), 32'(e));
        cmp({nm, "/d1_instret"}, 32'(b1.instret), 32'(c[3:0]));
    endtask

    function automatic out_t mk(input logic rq, mw, ad, irw, pcw, rgw,
                                input logic [1:0] rs, sa, sb, input logic [2:0] alu,
                                input logic [1:0] im);
        return {rq, mw, ad, irw, pcw, rgw, rs, sa, sb, alu, im, 1'b0};
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        return (o == OP_S) ? 2'd1 : (o == OP_B) ? 2'd2 : (o == OP_J) ? 2'd3 : 2'd0;
    endfunction

    // funct3 -> ALU code, laid out as a lookup word indexed by funct3
    function automatic logic [2:0] alu_of(input logic rtype, input logic [2:0] f3, input logic f7);
        logic [23:0] m;
        m = {3'd2, 3'd3, 3'd7, 3'd4, 3'd0, 3'd5, 3'd6, 3'd0};
        if (rtype && f3 == 3'b000 && f7) return SUB;
        return m[int'(f3)*3 +: 3];
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected per-cycle trace of one legal instruction, then applied and compared
    task automatic run_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, z, s, input int fw, mw);
        step_t q[$];
        logic [1:0] im;
        logic tk;
        im = imm_of(o);
        b0.op = o; b0.funct3 = f3; b0.funct7b5 = f7; b0.zero = z; b0.sign_flag = s;
        for (int i = 0; i < fw; i++)
            q.push_back('{1'b0, mk(1,0,0,0,0,0, 2'b10, 2'b00, 2'b10, ADD, im)});
        q.push_back('{1'b1, mk(1,0,0,1,1,0, 2'b10, 2'b00, 2'b10, ADD, im)});
        q.push_back('{rbit(), mk(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, ADD, im)});
        if (o == OP_L || o == OP_S) begin
            q.push_back('{rbit(), mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, ADD, im)});
            for (int i = 0; i <= mw; i++)
                q.push_back('{(i == mw), mk(1, o == OP_S, 1,0,0,0, 2'b00, 2'b00, 2'b00, ADD, im)});
            if (o == OP_L)
                q.push_back('{rbit(), mk(0,0,0,0,0,1, 2'b01, 2'b00, 2'b00, ADD, im)});
        end else if (o == OP_B) begin
            tk = f3[0] ^ (f3[2] ? s : z);
            q.push_back('{rbit(), mk(0,0,0,0,tk,0, 2'b00, 2'b10, 2'b00, SUB, im)});
        end else begin
            if (o == OP_J)
                q.push_back('{rbit(), mk(0,0,0,0,1,0, 2'b00, 2'b01, 2'b10, ADD, im)});
            else
                q.push_back('{rbit(), mk(0,0,0,0,0,0, 2'b00, 2'b10, (o == OP_R) ? 2'b00 : 2'b01,
                                         alu_of(o == OP_R, f3, f7), im)});
            q.push_back('{rbit(), mk(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, ADD, im)});
        end
        foreach (q[i]) begin
            b0.mem_ready = q[i].rdy;
            @(negedge CLK);
            chk(nm, q[i].e, cnt);
            @(posedge CLK); #1;
        end
        cnt++;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        cnt = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        vec_t tbl[19];
        ill_t ill[6];
        logic [31:0] c0;
        int cyc, rg, rgn, pw;
        logic [2:0] kalu;
        logic [1:0] ksb;

        tbl[0]  = '{"addi",   OP_I, 3'b000, 1'b0, 1'b0, 1'b0, 4, 3'b000, 2'b01, 4, 0};
        tbl[1]  = '{"addi_f7",OP_I, 3'b000, 1'b1, 1'b0, 1'b0, 4, 3'b000, 2'b01, 4, 0};
        tbl[2]  = '{"andi",   OP_I, 3'b111, 1'b0, 1'b0, 1'b0, 4, 3'b010, 2'b01, 4, 0};
        tbl[3]  = '{"add",    OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 4, 3'b000, 2'b00, 4, 0};
        tbl[4]  = '{"sub",    OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 4, 3'b001, 2'b00, 4, 0};
        tbl[5]  = '{"and",    OP_R, 3'b111, 1'b0, 1'b0, 1'b0, 4, 3'b010, 2'b00, 4, 0};
        tbl[6]  = '{"or",     OP_R, 3'b110, 1'b0, 1'b0, 1'b0, 4, 3'b011, 2'b00, 4, 0};
        tbl[7]  = '{"xor",    OP_R, 3'b100, 1'b0, 1'b0, 1'b0, 4, 3'b100, 2'b00, 4, 0};
        tbl[8]  = '{"slt",    OP_R, 3'b010, 1'b0, 1'b0, 1'b0, 4, 3'b101, 2'b00, 4, 0};
        tbl[9]  = '{"sll",    OP_R, 3'b001, 1'b0, 1'b0, 1'b0, 4, 3'b110, 2'b00, 4, 0};
        tbl[10] = '{"srl",    OP_R, 3'b101, 1'b0, 1'b0, 1'b0, 4, 3'b111, 2'b00, 4, 0};
        tbl[11] = '{"beq_t",  OP_B, 3'b000, 1'b0, 1'b1, 1'b0, 3, 3'b001, 2'b00, 0, 3};
        tbl[12] = '{"beq_nt", OP_B, 3'b000, 1'b0, 1'b0, 1'b0, 3, 3'b001, 2'b00, 0, 0};
        tbl[13] = '{"bne_t",  OP_B, 3'b001, 1'b0, 1'b0, 1'b0, 3, 3'b001, 2'b00, 0, 3};
        tbl[14] = '{"blt_t",  OP_B, 3'b100, 1'b0, 1'b0, 1'b1, 3, 3'b001, 2'b00, 0, 3};
        tbl[15] = '{"bge_nt", OP_B, 3'b101, 1'b0, 1'b0, 1'b1, 3, 3'b001, 2'b00, 0, 0};
        tbl[16] = '{"jal",    OP_J, 3'b000, 1'b0, 1'b0, 1'b0, 4, 3'b000, 2'b10, 4, 3};
        tbl[17] = '{"lw",     OP_L, 3'b010, 1'b0, 1'b0, 1'b0, 5, 3'b000, 2'b01, 5, 0};
        tbl[18] = '{"sw",     OP_S, 3'b010, 1'b0, 1'b0, 1'b0, 4, 3'b000, 2'b01, 0, 0};

        ill[0] = '{7'h7F, 3'b000, 1'b0, 2};
        ill[1] = '{OP_R,  3'b011, 1'b0, 3};
        ill[2] = '{OP_R,  3'b101, 1'b1, 3};
        ill[3] = '{OP_I,  3'b101, 1'b1, 3};
        ill[4] = '{OP_L,  3'b000, 1'b0, 3};
        ill[5] = '{OP_B,  3'b010, 1'b0, 3};

        // Reset state: FETCH selects, enables held low even with mem_ready high
        RST = 1'b0; cnt = 0;
        b0.op = 7'h00; b0.funct3 = 3'b000; b0.funct7b5 = 1'b0;
        b0.zero = 1'b0; b0.sign_flag = 1'b0; b0.mem_ready = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("reset", mk(0,0,0,0,0,0, 2'b10, 2'b00, 2'b10, ADD, 2'b00), 0);
        @(posedge CLK); #1;
        RST = 1'b1;

        // addi x1,x0,5 with three fetch wait cycles
        run_instr("addi_wait", OP_I, 3'b000, 1'b0, 1'b0, 1'b0, 3, 0);

        // Table: CPI and key-cycle controls with mem_ready tied high
        for (int v = 0; v < 19; v++) begin
            b0.op = tbl[v].op; b0.funct3 = tbl[v].f3; b0.funct7b5 = tbl[v].f7;
            b0.zero = tbl[v].z; b0.sign_flag = tbl[v].s; b0.mem_ready = 1'b1;
            c0 = b0.instret;
            cyc = 0; rg = 0; rgn = 0; pw = 0; kalu = 3'bxxx; ksb = 2'bxx;
            for (int k = 0; k < 12; k++) begin
                @(negedge CLK);
                cyc++;
                if (cyc == 3) begin kalu = b0.ALU_control; ksb = b0.ALUSrcB; end
                if (b0.RegWrite) begin rg = cyc; rgn++; end
                if (b0.PCWrite && cyc > 1) pw = cyc;
                @(posedge CLK); #1;
                if (b0.instret !== c0) break;
            end
            cmp({tbl[v].nm, "_cpi"}, cyc, tbl[v].cpi);
            cmp({tbl[v].nm, "_instret_inc"}, b0.instret - c0, 1);
            cmp({tbl[v].nm, "_alu_srcb"}, {27'b0, kalu, ksb}, {27'b0, tbl[v].alu, tbl[v].sb});
            cmp({tbl[v].nm, "_regwrite"}, rg * 16 + rgn, tbl[v].rg * 16 + ((tbl[v].rg != 0) ? 1 : 0));
            cmp({tbl[v].nm, "_pcwrite"}, pw, tbl[v].pw);
            cnt++;
        end

        // sw stalled in MEMWRITE, reset mid-request
        b0.op = OP_S; b0.funct3 = 3'b010; b0.funct7b5 = 1'b0; b0.mem_ready = 1'b1;
        repeat (3) begin @(posedge CLK); #1; end
        b0.mem_ready = 1'b0;
        @(negedge CLK);
        chk("sw_wait", mk(1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, ADD, 2'b01), cnt);
        #1 RST = 1'b0;
        #1 chk("rst_mid_sw", mk(0,0,0,0,0,0, 2'b10, 2'b00, 2'b10, ADD, 2'b01), 0);
        @(posedge CLK); #1;
        RST = 1'b1; cnt = 0;
        run_instr("post_rst_addi", OP_I, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);

        // Illegal encodings: dut0 traps for good, dut1 falls back to FETCH
        for (int k = 0; k < 6; k++) begin
            do_reset();
            b0.op = ill[k].op; b0.funct3 = ill[k].f3; b0.funct7b5 = ill[k].f7;
            b0.zero = 1'b0; b0.sign_flag = 1'b0; b0.mem_ready = 1'b1;
            for (int c = 1; c <= ill[k].stage; c++) begin
                @(negedge CLK);
                if (c == ill[k].stage) begin
                    cmp("ill_decide_en/d0", 32'({b0.mem_req, b0.MemWrite, b0.IRWrite, b0.PCWrite, b0.RegWrite, b0.illegal}), 0);
                    cmp("ill_decide_en/d1", 32'({b1.mem_req, b1.MemWrite, b1.IRWrite, b1.PCWrite, b1.RegWrite, b1.illegal}), 0);
                end
                @(posedge CLK); #1;
            end
            for (int t = 0; t < ((k == 0) ? 20 : 3); t++) begin
                b0.mem_ready = rbit();
                @(negedge CLK);
                cmp("trap/d0", 32'({b0.mem_req, b0.MemWrite, b0.IRWrite, b0.PCWrite, b0.RegWrite, b0.illegal}), 1);
                cmp("trap_instret/d0", b0.instret, 0);
                if (t == 0) begin
                    cmp("nop_fetch/d1", 32'({b1.mem_req, b1.illegal}), 2);
                    cmp("nop_instret/d1", 32'(b1.instret), 0);
                end
                @(posedge CLK); #1;
            end
        end

        // Random legal instruction stream against the trace model
        do_reset();
        for (int n = 0; n < 200; n++) begin
            int cls, fw, mw;
            logic [6:0] o;
            logic [2:0] f;
            logic f7;
            cls = int'($urandom_range(0, 5));
            f   = 3'($urandom_range(0, 7));
            f7  = rbit();
            fw  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            mw  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            case (cls)
                0: begin o = OP_L; f = 3'b010; end
                1: begin o = OP_S; f = 3'b010; end
                2, 3: begin
                    o = (cls == 2) ? OP_R : OP_I;
                    if (f == 3'b011) f = 3'b000;
                    if (f == 3'b101) f7 = 1'b0;
                end
                4: begin o = OP_B; f = {f[2], 1'b0, f[0]}; end
                default: o = OP_J;
            endcase
            run_instr("rand", o, f, f7, rbit(), rbit(), fw, mw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
